fpga_test_runner: RTL and testbench
===================================

Name: fpga_test_runner

Overview:
- Parametrised successor to the single-program FPGA test harness: loadable program and expected-output memories instead of a hard-coded case list.
- Executes a small program (ADD, ADDL, OUT, JMP, HALT) at one instruction per clock, streams OUT values, then compares them against the loaded expected list.
- Reports finished/success plus first failing index.
- Sits at FPGA top level as the self-check wrapper for generated test programs.

Parameters:
- MemoryElementWidth, 12, data/element width MW; all arithmetic is mod 2^MW.
- NLocal, 16, local memory words; address width LA = clog2(NLocal).
- NProg, 32, program memory slots; address width PA = clog2(NProg).
- NOut, 8, out channel depth; write position wraps.
- NExp, 8, expected-value slots.
- NSteps, 1000, step limit; used only with the optional feature.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level start; a 0→1 transition starts a run.
- load_valid  in  1  load strobe.
- load_ready  out  1  high only in IDLE.
- load_exp  in  1  0 = program write, 1 = expected write.
- load_addr  in  PA  slot index.
- load_data  in  3+LA+2*MW  instruction, or expected value in the low MW bits.
- out_valid  out  1  one-cycle pulse per executed OUT.
- out_data  out  MW  value emitted by OUT.
- finished  out  1  run complete.
- success  out  1  valid while finished=1.
- fail_index  out  PA  first mismatching expected index; all-ones if the count is wrong.
- steps  out  32  instructions executed in the current run.

Behaviour:
- Instruction layout [op(3) | dst/src(LA) | A(MW) | B(MW)].
  - 000 HALT.
  - 001 ADD: local[dst] = A + B.
  - 010 ADDL: local[dst] = local[A[LA-1:0]] + B.
  - 011 OUT: emit local[src].
  - 100 JMP: ip = A[PA-1:0].
  - 101–111: treated as HALT.
- Reset (asynchronous, active-low): state=IDLE; finished, success, out_valid, out_data, steps=0; fail_index=0; load_ready=1. Memories are not cleared.
- Loads are accepted when load_valid && load_ready; writes land on the next edge. Loads in any other state are ignored.
- States:
  - IDLE: run rises → EXEC, with ip, steps, outPos, outCount cleared.
  - EXEC: one instruction per cycle; steps+1 per cycle. HALT, or ip reaching NProg after increment → CHECK.
  - CHECK: one compare per cycle, k = 0..NExp-1, outMem[k] vs exp[k]. The first mismatch latches fail_index. If outCount != NExp, go straight to DONE with success=0 and fail_index = all-ones.
  - DONE: finished=1; success=1 only if the count matched and there was no mismatch. run=0 → IDLE with finished and success cleared.
- OUT: out_valid=1 with out_data on the following cycle. outMem[outPos]=value; outPos = (outPos+1) mod NOut; outCount saturates at 2^PA-1.
- If outCount > NOut, the run fails (count mismatch), even if NExp matches after wrap.
- ADDL reading a local written by the immediately preceding instruction sees the new value; no hazard stalls.
- run held high through DONE does not restart; a fresh rising edge is required.
- Reset mid-run aborts immediately to IDLE.

Optional Feature:
- FPGA_TEST_TIMEOUT_EN defined: in EXEC, when steps reaches NSteps, go to DONE with success=0 and fail_index = all-ones-minus-one.
- Undefined: there is no limit; a JMP loop runs until reset.

Test Plan:
- Load [ADD L0=3+2, OUT L0, HALT] with NExp=1 and exp[0]=5; pulse run → out_valid once with out_data=5; finished=1, success=1, steps=3.
- Same program with exp[0]=6 → finished=1, success=0, fail_index=0.
- [ADD L1=4095+3, ADDL L2=L1+1, OUT L1, OUT L2, HALT] with exp={2,3} → wrap-mod 2^12 gives outputs 2,3; success=1.
- 9 OUTs, NOut=8, NExp=8 → outPos wraps; count mismatch gives success=0, fail_index=all-ones.
- [JMP 0] with FPGA_TEST_TIMEOUT_EN and NSteps=1000 → finished after 1000 steps, success=0. Without the macro, finished stays 0 for 5000 cycles.
- Assert reset low mid-EXEC → all outputs 0 and load_ready=1 asynchronously. A load attempted during EXEC does not alter program memory (verified by a rerun).

Source files
------------

// File: rtl/fpga_test_runner.sv
// fpga_test_runner: loadable-program self-check harness that runs a program, streams OUT values
// and compares them with an expected list. Define FPGA_TEST_TIMEOUT_EN to bound a run at NSteps.
module fpga_test_runner #(
   parameter  int MemoryElementWidth = 12,
   parameter  int NLocal = 16,
   parameter  int NProg = 32,
   parameter  int NOut = 8,
   parameter  int NExp = 8,
   parameter  int NSteps = 1000,
   localparam int MW = MemoryElementWidth,
   localparam int LA = $clog2(NLocal),
   localparam int PA = $clog2(NProg),
   localparam int IW = 3 + LA + 2 * MW
) (
   input  logic          clock_i,
   input  logic          reset_ni,
   input  logic          run_i,
   input  logic          load_valid_i,
   output logic          load_ready_o,
   input  logic          load_exp_i,
   input  logic [PA-1:0] load_addr_i,
   input  logic [IW-1:0] load_data_i,
   output logic          out_valid_o,
   output logic [MW-1:0] out_data_o,
   output logic          finished_o,
   output logic          success_o,
   output logic [PA-1:0] fail_index_o,
   output logic [31:0]   steps_o
);
   localparam int OA = NOut > 1 ? $clog2(NOut) : 1;
   localparam int KA = NExp > 1 ? $clog2(NExp) : 1;
`ifdef FPGA_TEST_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif
   localparam logic [2:0] OP_ADD = 3'd1, OP_ADDL = 3'd2, OP_OUT = 3'd3, OP_JMP = 3'd4;

   typedef enum logic [1:0] {IDLE, EXEC, CHECK, DONE} state_e;

   logic [IW-1:0] prog_q    [NProg];
   logic [MW-1:0] exp_q     [2**KA];
   logic [MW-1:0] loc_q     [NLocal];
   logic [MW-1:0] out_mem_q [2**OA];

   state_e        state_q;
   logic          run_q, bad_q, finished_q, success_q, out_valid_q;
   logic [PA-1:0] ip_q, out_cnt_q, fail_q;
   logic [OA-1:0] out_pos_q;
   logic [KA-1:0] k_q;
   logic [31:0]   steps_q;
   logic [MW-1:0] out_data_q;

   logic [IW-1:0] instr;
   logic [2:0]    op;
   logic [LA-1:0] dst;
   logic [MW-1:0] a, b, src_val;
   logic          load_en, timeout, exec, halt, cnt_bad, mismatch;

   always_comb begin
      instr    = prog_q[ip_q];
      op       = instr[IW-1 -: 3];
      dst      = instr[2*MW +: LA];
      a        = instr[MW +: MW];
      b        = instr[MW-1:0];
      src_val  = loc_q[dst];
      load_en  = load_valid_i && state_q == IDLE;
      timeout  = TimeoutEn && steps_q == 32'(NSteps);
      exec     = state_q == EXEC && !timeout;
      halt     = !(op inside {OP_ADD, OP_ADDL, OP_OUT, OP_JMP});
      cnt_bad  = int'(out_cnt_q) != NExp || int'(out_cnt_q) > NOut;
      mismatch = out_mem_q[OA'(k_q)] != exp_q[k_q];
   end

   // Memories keep their contents across reset; the local file is read combinationally so
   // an ADDL sees a value written by the instruction just before it.
   always_ff @(posedge clock_i) begin
      if (load_en && !load_exp_i) prog_q[load_addr_i] <= load_data_i;
      if (load_en && load_exp_i && int'(load_addr_i) < NExp) exp_q[KA'(load_addr_i)] <= load_data_i[MW-1:0];
      if (exec && (op == OP_ADD || op == OP_ADDL)) loc_q[dst] <= (op == OP_ADD ? a : loc_q[a[LA-1:0]]) + b;
      if (exec && op == OP_OUT) out_mem_q[out_pos_q] <= src_val;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         run_q       <= 1'b0;
         ip_q        <= '0;
         steps_q     <= '0;
         out_pos_q   <= '0;
         out_cnt_q   <= '0;
         k_q         <= '0;
         bad_q       <= 1'b0;
         fail_q      <= '0;
         finished_q  <= 1'b0;
         success_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         run_q       <= run_i;
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (run_i && !run_q) begin
               state_q   <= EXEC;
               ip_q      <= '0;
               steps_q   <= '0;
               out_pos_q <= '0;
               out_cnt_q <= '0;
               k_q       <= '0;
               bad_q     <= 1'b0;
               fail_q    <= '0;
            end
            EXEC: if (timeout) begin
               state_q    <= DONE;
               finished_q <= 1'b1;
               success_q  <= 1'b0;
               fail_q     <= {{(PA-1){1'b1}}, 1'b0};
            end else begin
               steps_q <= steps_q + 32'd1;
               if (op == OP_OUT) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= src_val;
                  out_pos_q   <= int'(out_pos_q) == NOut - 1 ? '0 : out_pos_q + OA'(1);
                  out_cnt_q   <= out_cnt_q == '1 ? out_cnt_q : out_cnt_q + PA'(1);
               end
               if (op == OP_JMP) ip_q <= a[PA-1:0];
               else if (halt || int'(ip_q) == NProg - 1) state_q <= CHECK;
               else ip_q <= ip_q + PA'(1);
            end
            CHECK: if (cnt_bad) begin
               state_q    <= DONE;
               finished_q <= 1'b1;
               success_q  <= 1'b0;
               fail_q     <= '1;
            end else begin
               k_q   <= k_q + KA'(1);
               bad_q <= bad_q || mismatch;
               if (mismatch && !bad_q) fail_q <= PA'(k_q);
               if (int'(k_q) == NExp - 1) begin
                  state_q    <= DONE;
                  finished_q <= 1'b1;
                  success_q  <= !(bad_q || mismatch);
               end
            end
            DONE: if (!run_i) begin
               state_q    <= IDLE;
               finished_q <= 1'b0;
               success_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready_o = state_q == IDLE;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign finished_o   = finished_q;
   assign success_o    = success_q;
   assign fail_index_o = fail_q;
   assign steps_o      = steps_q;
endmodule

// File: tb/tb_fpga_test_runner.sv
// tb_fpga_test_runner: three runners (NExp = 1, 2, 8) share stimulus; table rows, corner
// sequences and random programs are checked against a program-level reference model.
module tb_fpga_test_runner;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, run, lv, lexp;
   logic [4:0] laddr;
   logic [30:0] ldata;
   logic [2:0] lr, ov, fin, suc;
   logic [2:0][11:0] od;
   logic [2:0][4:0] fidx;
   logic [2:0][31:0] stp;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      fpga_test_runner #(.NExp(g == 0 ? 1 : (g == 1 ? 2 : 8))) u (
         .clock_i(clk), .reset_ni(rst_n), .run_i(run), .load_valid_i(lv), .load_ready_o(lr[g]),
         .load_exp_i(lexp), .load_addr_i(laddr), .load_data_i(ldata), .out_valid_o(ov[g]),
         .out_data_o(od[g]), .finished_o(fin[g]), .success_o(suc[g]), .fail_index_o(fidx[g]),
         .steps_o(stp[g]));
   end

   typedef struct {
      logic [30:0] p[12];
      int n;
      int e[8];
      int g, s, f, st;
   } vec_t;

   vec_t tv[6];
   logic [30:0] pm[32];
   int expv[8];
   int loc[16];
   int m_outs[$];
   int m_steps;
   int total = 0, bad = 0;

   function automatic int ne(int g);
      return g == 0 ? 1 : (g == 1 ? 2 : 8);
   endfunction

   function automatic logic [30:0] ins(int op, int d, int a, int b);
      return {3'(op), 4'(d), 12'(a), 12'(b)};
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // Executes pm from slot 0 with plain integer arithmetic; commit keeps the local writes.
   function automatic void model(bit commit);
      int l[16];
      int ip, op, d, a, b;
      l = loc;
      ip = 0;
      m_steps = 0;
      m_outs.delete();
      while (m_steps < 2000) begin
         op = int'(pm[ip][30:28]);
         d  = int'(pm[ip][27:24]);
         a  = int'(pm[ip][23:12]);
         b  = int'(pm[ip][11:0]);
         m_steps++;
         if (op == 1) l[d] = (a + b) % 4096;
         else if (op == 2) l[d] = (l[a % 16] + b) % 4096;
         else if (op == 3) m_outs.push_back(l[d]);
         if (op == 4) ip = a % 32;
         else if (op == 0 || op > 4) break;
         else begin
            ip++;
            if (ip == 32) break;
         end
      end
      if (commit) loc = l;
   endfunction

   task automatic load(bit e, int addr, logic [30:0] data);
      @(negedge clk);
      lv = 1'b1;
      lexp = e;
      laddr = 5'(addr);
      ldata = data;
      @(negedge clk);
      lv = 1'b0;
   endtask

   task automatic load_all(int n);
      for (int i = 0; i < n; i++) load(1'b0, i, pm[i]);
      for (int i = 0; i < 8; i++) load(1'b1, i, 31'(expv[i]));
   endtask

   task automatic run_prog(int g, string nm, int ws, int wf, int wst);
      int es, ef, cyc;
      int got[$];
      logic [31:0] st_done;
      model(1'b0);
      es = 1;
      ef = 0;
      if (m_outs.size() != ne(g) || m_outs.size() > 8) begin
         es = 0;
         ef = 31;
      end else
         for (int k = 0; k < m_outs.size(); k++)
            if (es == 1 && m_outs[k] != expv[k]) begin
               es = 0;
               ef = k;
            end
      @(negedge clk);
      run = 1'b1;
      cyc = 0;
      while (!fin[g] && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (ov[g]) got.push_back(int'(od[g]));
      end
      chk({nm, " finished"}, fin[g], 1);
      chk({nm, " success"}, suc[g], es);
      chk({nm, " fail_index"}, fidx[g], ef);
      chk({nm, " steps"}, stp[g], m_steps);
      chk({nm, " out count"}, got.size(), m_outs.size());
      for (int k = 0; k < got.size() && k < m_outs.size(); k++) chk({nm, " out value"}, got[k], m_outs[k]);
      if (ws >= 0) chk({nm, " table success"}, suc[g], ws);
      if (wf >= 0) chk({nm, " table fail_index"}, fidx[g], wf);
      if (wst >= 0) chk({nm, " table steps"}, stp[g], wst);
      st_done = stp[g];
      repeat (3) @(negedge clk);
      chk({nm, " run held no restart"}, {fin[g], stp[g]}, {1'b1, st_done});
      run = 1'b0;
      @(negedge clk);
      chk({nm, " done cleared"}, {fin[g], suc[g]}, 0);
      repeat (12) @(negedge clk);
      model(1'b1);
   endtask

   initial begin
      int n, nout, k, t;
      rst_n = 1'b0;
      run = 1'b0;
      lv = 1'b0;
      lexp = 1'b0;
      laddr = '0;
      ldata = '0;

      tv[0].p[0] = ins(1, 0, 3, 2); tv[0].p[1] = ins(3, 0, 0, 0); tv[0].p[2] = ins(0, 0, 0, 0);
      tv[0].n = 3; tv[0].e[0] = 5; tv[0].g = 0; tv[0].s = 1; tv[0].f = 0; tv[0].st = 3;
      tv[1] = tv[0]; tv[1].e[0] = 6; tv[1].s = 0;
      tv[2].p[0] = ins(1, 1, 4095, 3); tv[2].p[1] = ins(2, 2, 1, 1); tv[2].p[2] = ins(3, 1, 0, 0);
      tv[2].p[3] = ins(3, 2, 0, 0); tv[2].p[4] = ins(0, 0, 0, 0);
      tv[2].n = 5; tv[2].e[0] = 2; tv[2].e[1] = 3; tv[2].g = 1; tv[2].s = 1; tv[2].f = 0; tv[2].st = 5;
      tv[3].p[0] = ins(1, 0, 7, 0);
      for (int i = 1; i <= 9; i++) tv[3].p[i] = ins(3, 0, 0, 0);
      tv[3].p[10] = ins(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) tv[3].e[i] = 7;
      tv[3].n = 11; tv[3].g = 2; tv[3].s = 0; tv[3].f = 31; tv[3].st = 11;
      tv[4] = tv[3]; tv[4].p[9] = ins(0, 0, 0, 0); tv[4].n = 10; tv[4].e[5] = 9;
      tv[4].s = 0; tv[4].f = 5; tv[4].st = 10;
      tv[5] = tv[4]; tv[5].e[5] = 7; tv[5].s = 1; tv[5].f = 0;

      #12;
      chk("reset outputs", {fin[2], suc[2], ov[2], od[2], fidx[2], stp[2]}, 0);
      chk("reset load_ready", lr, 3'b111);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < tv[r].n; i++) pm[i] = tv[r].p[i];
         for (int i = 0; i < 8; i++) expv[i] = tv[r].e[i];
         load_all(tv[r].n);
         run_prog(tv[r].g, $sformatf("row%0d", r), tv[r].s, tv[r].f, tv[r].st);
      end

      for (int i = 0; i < 32; i++) pm[i] = ins(1, 5, 0, 0);
      load_all(32);
      run_prog(2, "nprog_end", 0, 31, 32);

      for (int i = 0; i < 16; i++) pm[i] = ins(1, i, i * 37, 5);
      pm[16] = ins(0, 0, 0, 0);
      load_all(17);
      run_prog(2, "init_locals", 0, 31, 17);

      for (int it = 0; it < 20; it++) begin
         n = 0;
         nout = $urandom_range(6, 9);
         for (int j = 0; j < nout; j++) begin
            repeat ($urandom_range(0, 1)) begin
               pm[n] = ins($urandom_range(1, 2), $urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 4095));
               n++;
            end
            pm[n] = ins(3, $urandom_range(0, 15), 0, 0);
            n++;
         end
         t = $urandom_range(4, 7);
         pm[n] = ins(t == 4 ? 0 : t, 0, 0, 0);
         n++;
         model(1'b0);
         for (int i = 0; i < 8; i++) expv[i] = i < m_outs.size() ? m_outs[i] : $urandom_range(0, 4095);
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 7);
            expv[k] = expv[k] ^ 1;
         end
         load_all(n);
         run_prog(2, "rand", -1, -1, -1);
      end

      pm[0] = ins(4, 0, 0, 0);
      load(1'b0, 0, pm[0]);
      @(negedge clk);
      run = 1'b1;
      repeat (20) @(negedge clk);
      chk("exec load_ready low", lr[2], 0);
      chk("exec not finished", fin[2], 0);
      load(1'b0, 0, ins(0, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      chk("async reset outputs", {fin[2], suc[2], ov[2], od[2], fidx[2], stp[2]}, 0);
      chk("async reset load_ready", lr[2], 1);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b1;
`ifdef FPGA_TEST_TIMEOUT_EN
      k = 0;
      while (!fin[2] && k < 1200) begin
         @(negedge clk);
         k++;
      end
      chk("timeout finished", fin[2], 1);
      chk("timeout success", suc[2], 0);
      chk("timeout fail_index", fidx[2], 30);
      chk("timeout steps", stp[2], 1000);
`else
      repeat (5000) @(negedge clk);
      chk("loop still running", fin[2], 0);
      chk("loop steps advance", stp[2] > 32'd4000, 1);
`endif
      run = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
